// File: rtl/hist_eq_lut_engine.sv
// hist_eq_lut_engine
//
// Builds a histogram-equalization lookup table for the stored grayscale image.
// On start the engine clears its bins, scans every image pixel once through the
// image memory read port, accumulates the histogram into a CDF and writes one
// LUT entry per intensity. The display path reads equalized pixels through the
// registered LUT port. Without a valid table the LUT port passes raw pixels.
//
// Ports:
//   rClk        system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       single-cycle run request (ignored unless idle)
//   busy        high from the accepting edge until done
//   done        one-cycle pulse when the table is complete
//   mem_re      image memory read enable
//   mem_addr    image memory read address
//   mem_rd      image memory read data, valid one cycle after mem_re
//   lut_addr    raw pixel from the display path
//   lut_data    equalized pixel, one cycle after lut_addr
//   lut_valid   LUT holds a complete, current table
//
// Optional feature (macro HIST_READBACK_EN):
//   hist_addr   histogram bin to read back
//   hist_count  bin contents, one cycle latency; reads 0 outside idle
//
// Schedule after the accepting edge: 2^DATA_WIDTH clear cycles, 2^ADDR_WIDTH
// read cycles, one drain cycle, 2^DATA_WIDTH accumulate cycles, then done.

module hist_eq_lut_engine #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned PIXEL_DEPTH = 255
) (
  input  logic                  rClk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] lut_addr,
  output logic [DATA_WIDTH-1:0] lut_data,
  output logic                  lut_valid
`ifdef HIST_READBACK_EN
  ,
  input  logic [DATA_WIDTH-1:0] hist_addr,
  output logic [ADDR_WIDTH:0]   hist_count
`endif
);

  localparam int unsigned NumBins = 2 ** DATA_WIDTH;
  localparam int unsigned CntW    = ADDR_WIDTH + 1;
  localparam int unsigned ProdW   = ADDR_WIDTH + 1 + DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StScan,
    StDrain,
    StAccum,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] idx_q, idx_d;
  logic [CntW-1:0]       cdf_q, cdf_d;
  logic                  busy_q, busy_d;
  logic                  lut_valid_q, lut_valid_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] lut_data_q;

  // Bin and LUT storage are not reset: CLEAR zeroes the bins and lut_valid
  // gates the LUT contents.
  logic [CntW-1:0]       bin_q [NumBins];
  logic [DATA_WIDTH-1:0] lut_q [NumBins];

  logic                  bin_clr;
  logic                  lut_we;
  logic [ProdW-1:0]      prod;
  logic [ProdW-1:0]      scaled;
  logic [DATA_WIDTH-1:0] lut_wdata;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cdf_d       = cdf_q;
    busy_d      = busy_q;
    lut_valid_d = lut_valid_q;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    bin_clr     = 1'b0;
    lut_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StClear;
          busy_d      = 1'b1;
          lut_valid_d = 1'b0;
          idx_d       = '0;
          cdf_d       = '0;
        end
      end
      StClear: begin
        bin_clr = 1'b1;
        idx_d   = idx_q + DATA_WIDTH'(1);
        if (idx_q == '1) begin
          state_d    = StScan;
          mem_re_d   = 1'b1;
          mem_addr_d = '0;
        end
      end
      StScan: begin
        if (mem_addr_q == '1) begin
          mem_addr_d = '0;
          state_d    = StDrain;
        end else begin
          mem_re_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
      end
      // The last read's data lands during this cycle and is counted at its end.
      StDrain: begin
        state_d = StAccum;
        idx_d   = '0;
      end
      StAccum: begin
        lut_we = 1'b1;
        cdf_d  = cdf_q + bin_q[idx_q];
        idx_d  = idx_q + DATA_WIDTH'(1);
        if (idx_q == '1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy_d      = 1'b0;
        lut_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // LUT entry uses the running CDF including the current bin, scaled to the
  // output range and clamped.
  always_comb begin
    prod      = ProdW'(cdf_d) * ProdW'(PIXEL_DEPTH);
    scaled    = prod >> ADDR_WIDTH;
    lut_wdata = (scaled > ProdW'(PIXEL_DEPTH)) ? DATA_WIDTH'(PIXEL_DEPTH)
                                               : scaled[DATA_WIDTH-1:0];
  end

  always_ff @(posedge rClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cdf_q       <= '0;
      busy_q      <= 1'b0;
      lut_valid_q <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      rd_vld_q    <= 1'b0;
      lut_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cdf_q       <= cdf_d;
      busy_q      <= busy_d;
      lut_valid_q <= lut_valid_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      rd_vld_q    <= mem_re_q;
      lut_data_q  <= lut_valid_q ? lut_q[lut_addr] : lut_addr;
    end
  end

  // Read-modify-write on the bin array completes within one cycle, so
  // back-to-back identical pixels see the previous increment directly.
  always_ff @(posedge rClk) begin
    if (bin_clr) begin
      bin_q[idx_q] <= '0;
    end else if (rd_vld_q) begin
      bin_q[mem_rd] <= bin_q[mem_rd] + CntW'(1);
    end
    if (lut_we) begin
      lut_q[idx_q] <= lut_wdata;
    end
  end

`ifdef HIST_READBACK_EN
  logic [ADDR_WIDTH:0] hist_count_q;

  always_ff @(posedge rClk or negedge rst_n) begin
    if (!rst_n) begin
      hist_count_q <= '0;
    end else begin
      hist_count_q <= (state_q == StIdle) ? bin_q[hist_addr] : '0;
    end
  end

  assign hist_count = hist_count_q;
`endif

  assign busy      = busy_q;
  assign done      = (state_q == StDone);
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign lut_data  = lut_data_q;
  assign lut_valid = lut_valid_q;

endmodule

// File: tb/tb_hist_eq_lut_engine.sv
// Self-checking bench for hist_eq_lut_engine: image memory model, reference LUT
// model, vector table of known LUT values and a scoreboard for LUT port reads.

module tb_hist_eq_lut_engine;

  localparam int DW   = 8;
  localparam int AW   = 14;
  localparam int NPIX = 1 << AW;
  localparam int NBIN = 1 << DW;
  localparam int LAT  = 256 + NPIX + 1 + 256;

  logic          rClk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd;
  logic [DW-1:0] lut_addr;
  logic [DW-1:0] lut_data;
  logic          lut_valid;
`ifdef HIST_READBACK_EN
  logic [DW-1:0] hist_addr;
  logic [AW:0]   hist_count;
`endif

  always #5 rClk = ~rClk;

  hist_eq_lut_engine dut (
    .rClk      (rClk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .lut_valid (lut_valid)
`ifdef HIST_READBACK_EN
    ,
    .hist_addr (hist_addr),
    .hist_count(hist_count)
`endif
  );

  // Image memory: one-cycle read latency.
  logic [DW-1:0] img [NPIX];
  always @(posedge rClk) begin
    if (mem_re) mem_rd <= img[mem_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scan address monitor.
  int            scan_err;
  int            n_reads;
  logic [AW-1:0] exp_addr;
  always @(negedge rClk) begin
    if (rst_n === 1'b1 && mem_re === 1'b1) begin
      if (mem_addr !== exp_addr) scan_err++;
      exp_addr++;
      n_reads++;
    end
  end

  // Scoreboard for LUT port reads.
  typedef struct {
    string         name;
    logic [DW-1:0] exp;
  } sb_t;
  sb_t sb[$];

  always @(posedge rClk) begin
    #1;
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      chk(e.name, 32'(lut_data), 32'(e.exp));
    end
  end

  // Known LUT values per scenario (0 const 0x40, 1 ramp, 2 half 0x00 / 0xFF).
  typedef struct {
    string         name;
    int            scen;
    logic [DW-1:0] addr;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input string n, input int s, input logic [DW-1:0] a,
                         input logic [DW-1:0] e);
    vec_t v;
    v.name = n;
    v.scen = s;
    v.addr = a;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Reference model: histogram, CDF, scaled and clamped.
  logic [DW-1:0] exp_lut [NBIN];
  task automatic build_model();
    int hist [NBIN];
    int cdf;
    int val;
    for (int i = 0; i < NBIN; i++) hist[i] = 0;
    for (int p = 0; p < NPIX; p++) hist[img[p]]++;
    cdf = 0;
    for (int i = 0; i < NBIN; i++) begin
      cdf += hist[i];
      val = (cdf * 255) >> AW;
      if (val > 255) val = 255;
      exp_lut[i] = DW'(val);
    end
  endtask

  task automatic fill(input int kind);
    for (int p = 0; p < NPIX; p++) begin
      case (kind)
        0:       img[p] = 8'h40;
        1:       img[p] = DW'(p);
        default: img[p] = (p % 2 == 1) ? 8'hFF : 8'h00;
      endcase
    end
  endtask

  task automatic lut_read(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    sb_t s;
    @(negedge rClk);
    lut_addr = a;
    s.name = n;
    s.exp  = e;
    sb.push_back(s);
  endtask

  task automatic check_lut(input int scen);
    build_model();
    for (int v = 0; v < NBIN; v++) begin
      lut_read($sformatf("lut_s%0d_model[%02h]", scen, v), DW'(v), exp_lut[v]);
    end
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) lut_read(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end
    @(negedge rClk);
    @(negedge rClk);
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  task automatic do_run(input bit inject);
    int cyc;
    bit seen;
    scan_err = 0;
    n_reads  = 0;
    exp_addr = '0;
    @(negedge rClk);
    start = 1'b1;
    @(posedge rClk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
    chk("lut_valid_cleared", 32'(lut_valid), 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LAT + 100) begin
      @(posedge rClk);
      cyc++;
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else if (inject) begin
        if (cyc == 5000) start = 1'b1;
        if (cyc == 5001) start = 1'b0;
        if (cyc == 6000) lut_addr = 8'h5A;
        if (cyc == 6001) begin
          chk("midrun_passthru", 32'(lut_data), 32'h5A);
          chk("midrun_lut_valid", 32'(lut_valid), 0);
          chk("midrun_busy", 32'(busy), 1);
`ifdef HIST_READBACK_EN
          chk("midrun_hist_count", 32'(hist_count), 0);
`endif
        end
      end
    end
    chk("done_latency", 32'(cyc), 32'(LAT));
    chk("scan_reads", 32'(n_reads), 32'(NPIX));
    chk("scan_addr_seq_err", 32'(scan_err), 0);
    @(posedge rClk);
    #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
    chk("lut_valid_after_done", 32'(lut_valid), 1);
    chk("mem_addr_returns_0", 32'(mem_addr), 0);
  endtask

  initial begin
    int k;
    add_vec("const_lut[00]", 0, 8'h00, 8'h00);
    add_vec("const_lut[3F]", 0, 8'h3F, 8'h00);
    add_vec("const_lut[40]", 0, 8'h40, 8'hFF);
    add_vec("const_lut[FF]", 0, 8'hFF, 8'hFF);
    add_vec("ramp_lut[00]",  1, 8'h00, 8'h00);
    add_vec("ramp_lut[7F]",  1, 8'h7F, 8'h7F);
    add_vec("ramp_lut[FE]",  1, 8'hFE, 8'hFE);
    add_vec("ramp_lut[FF]",  1, 8'hFF, 8'hFF);
    add_vec("half_lut[00]",  2, 8'h00, 8'h7F);
    add_vec("half_lut[7F]",  2, 8'h7F, 8'h7F);
    add_vec("half_lut[FE]",  2, 8'hFE, 8'h7F);
    add_vec("half_lut[FF]",  2, 8'hFF, 8'hFF);

    rst_n    = 1'b1;
    start    = 1'b0;
    lut_addr = 8'h00;
`ifdef HIST_READBACK_EN
    hist_addr = 8'h00;
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_lut_data", 32'(lut_data), 0);
    chk("rst_lut_valid", 32'(lut_valid), 0);
`ifdef HIST_READBACK_EN
    chk("rst_hist_count", 32'(hist_count), 0);
`endif
    repeat (3) @(negedge rClk);
    rst_n = 1'b1;

    // Pass-through before any table exists.
    @(negedge rClk);
    lut_addr = 8'h5A;
    @(posedge rClk);
    #1;
    chk("pre_passthru", 32'(lut_data), 32'h5A);
    chk("pre_lut_valid", 32'(lut_valid), 0);

    // Constant image with a mid-scan start that must be ignored.
    fill(0);
    do_run(1'b1);
    check_lut(0);
`ifdef HIST_READBACK_EN
    @(negedge rClk);
    hist_addr = 8'h40;
    @(posedge rClk);
    #1;
    chk("hist_count[40]", 32'(hist_count), 32'(NPIX));
    @(negedge rClk);
    hist_addr = 8'h41;
    @(posedge rClk);
    #1;
    chk("hist_count[41]", 32'(hist_count), 0);
`endif

    fill(1);
    do_run(1'b0);
    check_lut(1);

    // Alternating 0x00 / 0xFF back to back exercises repeated bin updates.
    fill(2);
    do_run(1'b0);
    check_lut(2);

    // Abort mid-scan with reset, then rerun the constant image.
    @(negedge rClk);
    lut_addr = 8'h77;
    start    = 1'b1;
    @(negedge rClk);
    start = 1'b0;
    k = 0;
    while (!(mem_re === 1'b1 && mem_addr == AW'(8000)) && k < 20000) begin
      @(negedge rClk);
      k++;
    end
    chk("abort_point_reached", 32'(k < 20000), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_mem_re", 32'(mem_re), 0);
    chk("abort_mem_addr", 32'(mem_addr), 0);
    chk("abort_lut_data", 32'(lut_data), 0);
    chk("abort_lut_valid", 32'(lut_valid), 0);
    repeat (2) @(negedge rClk);
    rst_n = 1'b1;
    fill(0);
    do_run(1'b0);
    check_lut(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
